// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift/rotate unit, one bit position per clock with start/busy/done handshake
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [CNTW-1:0]  Cnt,
  input  logic [1:0]       Op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Out
);
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  state_t           r_state, w_next;
  logic [CNTW-1:0]  r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_out, w_shifted;
  logic             r_busy, r_done, w_accept;
  always_comb begin
    w_accept  = start && r_state != SHIFT;
    w_shifted = r_op[0] ? (r_op[1] ? {1'b0, r_out[WIDTH-1:1]} : {r_out[WIDTH-2:0], 1'b0})
                        : (r_op[1] ? {r_out[0], r_out[WIDTH-1:1]} : {r_out[WIDTH-2:0], r_out[WIDTH-1]});
    w_next    = w_accept ? ((Cnt != '0) ? SHIFT : FIN)
              : (r_state == SHIFT) ? ((r_cnt <= 1) ? FIN : SHIFT)
              : IDLE;
  end
  // busy/done are registered from the next state so no input reaches an output combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= w_next == SHIFT;
      r_done  <= w_next == FIN;
      if (w_accept) begin
        r_out <= In;
        r_cnt <= Cnt;
        r_op  <= Op;
      end else if (r_state == SHIFT) begin
        r_out <= w_shifted;
        r_cnt <= r_cnt - CNTW'(r_cnt != '0);
      end
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign Out  = r_out;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: scoreboard bench for seq_shifter; stimulus queues expected results, a monitor checks on done
module tb_seq_shifter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in_v = '0;
  logic [3:0]  cnt_v = '0;
  logic [1:0]  op_v = '0;
  logic        busy, done;
  logic [15:0] out_v;
  typedef struct {
    logic [15:0] out;
    int          n;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int busy_run = 0;
  seq_shifter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .In(in_v), .Cnt(cnt_v), .Op(op_v),
    .busy(busy), .done(done), .Out(out_v)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) busy_run = 0;
    else begin
      if (busy) busy_run++;
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=%0h required=none", out_v);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out", int'(out_v), int'(e.out));
          chk("busy_cycles", busy_run, e.n);
          chk("busy_with_done", int'(busy), 0);
        end
        busy_run = 0;
      end
    end
  end
  task automatic issue(input logic [15:0] i, input logic [3:0] c, input logic [1:0] o, input logic [15:0] r);
    @(posedge clk);
    #1;
    in_v = i; cnt_v = c; op_v = o; start = 1'b1;
    q.push_back('{out: r, n: int'(c)});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=pending%0d required=0", q.size());
      q.delete();
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", int'(out_v), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h8001, 4'd1, 2'b00, 16'h0003);  wait_idle();
    issue(16'h8001, 4'd4, 2'b01, 16'h0010);  wait_idle();
    issue(16'h8001, 4'd1, 2'b10, 16'hC000);  wait_idle();
    issue(16'h8001, 4'd15, 2'b11, 16'h0001); wait_idle();
    issue(16'h8001, 4'd15, 2'b00, 16'hC000); wait_idle();
    issue(16'hA5A5, 4'd0, 2'b10, 16'hA5A5);  wait_idle();
    // a start issued mid-operation must be ignored
    issue(16'h00FF, 4'd8, 2'b01, 16'hFF00);
    in_v = 16'h1234; cnt_v = 4'd3; op_v = 2'b00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    // back-to-back: second start held during FIN
    issue(16'h8001, 4'd2, 2'b01, 16'h0004);
    repeat (2) @(posedge clk);
    #1;
    in_v = 16'h0003; cnt_v = 4'd1; op_v = 2'b11; start = 1'b1;
    q.push_back('{out: 16'h0001, n: 1});
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", int'(busy), 1);
    wait_idle();
    // asynchronous reset mid-SHIFT
    issue(16'hBEEF, 4'd10, 2'b00, 16'h0000);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_rst_out", int'(out_v), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0004, 4'd2, 2'b10, 16'h0001);
    wait_idle();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Multi-cycle 16-bit shift/rotate unit for the pipelined datapath. It is the sequential counterpart of the combinational barrel shifter: one bit position per clock, controlled by a start/busy/done handshake.
Used in the execute stage where area matters more than latency. The stall logic holds the pipeline while busy is high.
Op encoding is the same as the ISA shifter: 00 rotate left, 01 shift left logical, 10 rotate right, 11 shift right logical.

Parameters:
WIDTH, 16, data width in bits
CNTW, 4, shift-count width; maximum shift is 2^CNTW-1

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a new operation; sampled only when busy=0
In  input  WIDTH  operand, captured on an accepted start
Cnt  input  CNTW  shift amount, captured on an accepted start
Op  input  2  operation select, captured on an accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; Out is valid from this cycle on
Out  output  WIDTH  result register

Behaviour:
- Reset (rst_n=0, any time, including mid-operation):
  - takes effect immediately and asynchronously;
  - state=IDLE, Out=0, busy=0, done=0;
  - internal count cleared; any in-flight operation is discarded.
- States: IDLE, SHIFT, FIN.
- IDLE:
  - start=1 → capture In into the working register (Out), Cnt into a down-counter, Op into an op register;
  - next state is SHIFT if Cnt≠0, else FIN;
  - busy=1 from the next cycle.
- SHIFT, once per cycle, one bit position:
  - op 00: Out <= {Out[WIDTH-2:0], Out[WIDTH-1]}
  - op 01: Out <= {Out[WIDTH-2:0], 1'b0}
  - op 10: Out <= {Out[0], Out[WIDTH-1:1]}
  - op 11: Out <= {1'b0, Out[WIDTH-1:1]}
  - The counter decrements each cycle. When the counter reaches 1 on the current edge, next state is FIN.
- FIN:
  - busy=0, done=1 for exactly this cycle, Out holds the final result;
  - start=1 in FIN is accepted exactly as in IDLE (back-to-back);
  - otherwise next state is IDLE.
- Latency: done asserts Cnt+1 cycles after the accepting edge; Cnt=0 → done on the next cycle with Out=In.
- Output hold: Out holds its value in IDLE and FIN until the next accepted start. Inputs In, Cnt and Op are don't-care except on an accepting edge.
- start while busy=1 is ignored: no capture, no error, the current operation is unaffected.
- busy and done are never high in the same cycle.
- Count arithmetic is unsigned CNTW bits; the counter never wraps below 0.
- Cnt=15 on a rotate returns In rotated by 15 positions (not In).
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then In=16'h8001, Op=00, Cnt=1, one start pulse → busy for 1 cycle; done on cycle 2 with Out=16'h0003.
- In=16'h8001, Op=01, Cnt=4 → busy for 4 cycles; done on cycle 5 with Out=16'h0010. Repeat with Op=10, Cnt=1 → Out=16'hC000.
- In=16'h8001, Op=11, Cnt=15 → done on cycle 16 with Out=16'h0001. Repeat with Op=00, Cnt=15 → Out=16'hC000.
- Cnt=0, In=16'hA5A5, any Op → done on the next cycle, Out=16'hA5A5, busy never asserts.
- Start accepted with In=16'h00FF, Op=01, Cnt=8; second start with In=16'h1234 issued while busy → ignored, Out=16'hFF00. Then a start held high during FIN → back-to-back op starts, no idle cycle.
- Drop rst_n asynchronously mid-SHIFT (Cnt=10, 3 cycles in) → Out=0, busy=0, done=0 immediately. After release, a new Op=10, Cnt=2, In=16'h0004 gives Out=16'h0001.
